// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the layer-1 5x5 convolution accelerator: streams one image
// frame into the accelerator and writes its result stream to the result buffer.
module conv_frame_sequencer #(
    parameter int unsigned IMG_WIDTH     = 28,
    parameter int unsigned IMG_HEIGHT    = 28,
    parameter int unsigned K             = 5,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned OUT_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  img_rd_en,
    output logic [ADDR_WIDTH-1:0] img_rd_addr,
    input  logic [DATA_WIDTH-1:0] img_rd_data,
    output logic                  acc_valid_in,
    output logic [DATA_WIDTH-1:0] acc_pixel_in,
    input  logic [OUT_WIDTH-1:0]  acc_result,
    input  logic                  acc_result_valid,
    output logic                  res_wr_en,
    output logic [ADDR_WIDTH-1:0] res_wr_addr,
    output logic [OUT_WIDTH-1:0]  res_wr_data,
    output logic [ADDR_WIDTH-1:0] result_count
);

    localparam int unsigned N_PIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned OUT_W  = IMG_WIDTH - K + 1;
    localparam int unsigned OUT_H  = IMG_HEIGHT - K + 1;
    localparam int unsigned M_RES  = OUT_W * OUT_H;
    localparam int unsigned GAP_W  = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(N_PIX - 1);
    localparam logic [ADDR_WIDTH-1:0] RES_TOTAL = ADDR_WIDTH'(M_RES);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic             rd_en_d1;

    logic start_accept;
    logic capture_phase;
    logic res_accept;
    logic res_overrun;
    logic drain_timeout;

    assign start_accept  = (state == S_IDLE) && start;
    assign capture_phase = (state == S_STREAM) || (state == S_FLUSH) || (state == S_DRAIN);
    assign res_accept    = capture_phase && acc_result_valid && (result_count < RES_TOTAL);
    assign res_overrun   = capture_phase && acc_result_valid && (result_count >= RES_TOTAL);
    // A result landing on the expiry cycle cancels the timeout.
    assign drain_timeout = (state == S_DRAIN) && !acc_result_valid && (gap_cnt == GAP_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (img_rd_addr == LAST_PIX) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((result_count == RES_TOTAL) || drain_timeout) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status and read-side outputs are driven from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            img_rd_en   <= 1'b0;
            img_rd_addr <= '0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            img_rd_en <= (state_nxt == S_STREAM);
            if ((state == S_STREAM) && (state_nxt == S_STREAM)) begin
                img_rd_addr <= img_rd_addr + ADDR_WIDTH'(1);
            end else begin
                img_rd_addr <= '0;
            end
        end
    end

    // Two-stage pixel pipeline: buffer read latency plus one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_d1     <= 1'b0;
            acc_valid_in <= 1'b0;
            acc_pixel_in <= '0;
        end else begin
            rd_en_d1     <= img_rd_en;
            acc_valid_in <= rd_en_d1;
            if (rd_en_d1) begin
                acc_pixel_in <= img_rd_data;
            end
        end
    end

    // Result capture into the linear result buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_wr_en    <= 1'b0;
            res_wr_addr  <= '0;
            res_wr_data  <= '0;
            result_count <= '0;
        end else begin
            res_wr_en <= res_accept;
            if (res_accept) begin
                res_wr_addr <= result_count;
                res_wr_data <= acc_result;
            end
            if (start_accept) begin
                result_count <= '0;
            end else if (res_accept) begin
                result_count <= result_count + ADDR_WIDTH'(1);
            end
        end
    end

    // Inter-result gap counter, only meaningful while draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if ((state == S_DRAIN) && !acc_result_valid) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end else begin
            gap_cnt <= '0;
        end
    end

    // Sticky error: overrun or drain timeout, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            error <= 1'b0;
        end else if (start_accept) begin
            error <= 1'b0;
        end else if (res_overrun || drain_timeout) begin
            error <= 1'b1;
        end
    end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller for the layer-1 5x5 convolution accelerator.
- On `start`, reads one IMG_WIDTH x IMG_HEIGHT frame from a synchronous-read image buffer and streams it pixel-per-cycle into the accelerator's `valid_in`/`pixel_in`.
- Collects the accelerator's `result_valid`/result stream and writes each result to a result buffer at a linear output address.
- Signals `done` when exactly OUT_W*OUT_H results are stored (OUT_W = IMG_WIDTH-K+1, OUT_H = IMG_HEIGHT-K+1). Flags `error` on drain timeout or result overrun.

Parameters:
- IMG_WIDTH, 28, input frame width in pixels
- IMG_HEIGHT, 28, input frame height in pixels
- K, 5, kernel size; sets the expected output count
- DATA_WIDTH, 8, pixel width
- OUT_WIDTH, 32, accelerator result width
- ADDR_WIDTH, 10, image and result buffer address width; must cover IMG_WIDTH*IMG_HEIGHT
- DRAIN_TIMEOUT, 64, maximum gap in cycles between results during drain before `error`

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at frame end
- error  out  1  sticky; cleared on accepted start or rst
- img_rd_en  out  1  image buffer read strobe
- img_rd_addr  out  ADDR_WIDTH  image read address
- img_rd_data  in  DATA_WIDTH  read data, valid the cycle after img_rd_en
- acc_valid_in  out  1  to accelerator valid_in
- acc_pixel_in  out  DATA_WIDTH  to accelerator pixel_in
- acc_result  in  OUT_WIDTH  accelerator result (signed)
- acc_result_valid  in  1  accelerator result_valid
- res_wr_en  out  1  result buffer write strobe
- res_wr_addr  out  ADDR_WIDTH  result address, 0..OUT_W*OUT_H-1, row-major
- res_wr_data  out  OUT_WIDTH  registered copy of acc_result
- result_count  out  ADDR_WIDTH  results written this frame

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE. A reset mid-frame aborts immediately: `acc_valid_in` and `res_wr_en` are low from the next cycle, and counters are zeroed.
- All outputs are registered.
- States: IDLE, STREAM, FLUSH, DRAIN, DONE.
- IDLE:
  - `start`=1 -> STREAM.
  - Clears `error`, the pixel counter and `result_count`.
- STREAM:
  - `img_rd_en`=1 every cycle; `img_rd_addr` runs 0..N-1, N = IMG_WIDTH*IMG_HEIGHT, contiguous with no gaps.
  - After issuing addr N-1 -> FLUSH.
- FLUSH: one cycle, lets the last read return, -> DRAIN.
- Read pipeline:
  - `acc_valid_in` is `img_rd_en` delayed 2 cycles.
  - `acc_pixel_in` is `img_rd_data` registered in the cycle after the read.
  - With `start` at cycle 0: `img_rd_en` is high cycles 1..N and `acc_valid_in` is high cycles 3..N+2.
  - Exactly N valid pixels per frame, so the accelerator's window generator wraps aligned at frame boundaries.
- Result capture (STREAM, FLUSH, DRAIN):
  - When `acc_result_valid`=1 and `result_count` < M (M = OUT_W*OUT_H), then next cycle: `res_wr_en`=1, `res_wr_data`=`acc_result`, `res_wr_addr`=`result_count`, and `result_count` increments.
  - If `result_count` = M when `acc_result_valid`=1: no write, and `error` sets (overrun).
  - `acc_result_valid` in IDLE or DONE is ignored; no write, no error.
- DRAIN:
  - Gap counter resets on each `acc_result_valid` and increments otherwise.
  - `result_count` reaches M -> DONE.
  - Gap counter reaches DRAIN_TIMEOUT -> `error`=1 and -> DONE.
- DONE:
  - `done`=1 for exactly one cycle, then -> IDLE.
  - `start` during DONE is ignored.
- `start` while `busy` is ignored.
- Simultaneous events:
  - A result arriving on the same cycle the gap counter expires is written, and the timeout is cancelled.
  - If the Mth result and the FLUSH->DRAIN transition coincide, go to DONE on the first DRAIN cycle.
- `result_count` and `error` hold their final values in IDLE until the next accepted `start`.

Test Plan:
- Nominal frame: `start` at cycle 0 with a behavioral accelerator model, 28x28 all-ones image and all K=1 (25 per output) -> `img_rd_addr` 0..783 on cycles 1..784; `acc_valid_in` cycles 3..786; 576 writes to addr 0..575 with data 25; one `done` pulse; `error`=0; `result_count`=576.
- Timeout: model stops emitting after 100 results -> `error`=1 exactly 64 idle DRAIN cycles after the last result; `done` pulse; `result_count`=100; no further writes.
- Overrun: model emits 577 results -> 576 writes, `error`=1, 577th not written, `done` still pulses.
- Busy `start`: pulse `start` at cycles 10 and 500 and on the `done` cycle -> all ignored, exactly one frame streamed; `start` the cycle after `done` begins a new frame, with `error` cleared and addr restarting at 0.
- Reset mid-stream: assert `rst` at read addr 300 -> next cycle all outputs 0 and state IDLE; a subsequent `start` (with the accelerator also reset) yields a clean 576-result frame.
- Stray results: `acc_result_valid` pulses while IDLE -> no `res_wr_en`, `error` stays 0, `result_count` unchanged.
